// File: rtl/dma_out_pkg.sv
// Shared definitions for the DMA engines: FSM encoding, timer and status layout.
package dma_out_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // timerInit value meaning "start as soon as the config is seen"
    localparam logic [31:0] TIMER_ALL_ONES = 32'hFFFF_FFFF;

    // status word layout, common with the stream-to-memory engine
    localparam int STATUS_OVF_BIT = 0;
    localparam int STATUS_OUT_LSB = 16;
    localparam int STATUS_OUT_W   = 8;

endpackage

// File: rtl/dma_out_fifo.sv
// Read-data buffer: synchronous FIFO with flush, occupancy count, async reset.
module dma_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // pointer and occupancy bookkeeping; flush discards everything at once
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // storage array; no reset needed, contents are only read when non-empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/dma_out.sv
// Memory-to-stream DMA: issues sequential reads under FIFO credit control and
// streams the returned words out with t0_last on the final beat.
module dma_out
    import dma_out_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [31:0]       ctimer,
    input  logic              config_valid,
    output logic              config_ready,
    input  logic [31:0]       config_payload_startAddr,
    input  logic [31:0]       config_payload_length,
    input  logic [31:0]       config_payload_timerInit,
    input  logic              config_payload_reverse,
    input  logic              dmaReset,
    output logic [31:0]       status,
    output logic              strobe_complete,
    output logic              interrupt,
    input  logic              interrupt_clear,
    output logic [31:0]       i0_addr,
    output logic              i0_valid,
    input  logic              i0_ready,
    input  logic [DATA_W-1:0] i0_rdata,
    input  logic              i0_rdata_valid,
    output logic [DATA_W-1:0] t0_data,
    output logic              t0_last,
    output logic              t0_valid,
    input  logic              t0_ready
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    state_t            state, state_nx;
    logic [31:0]       q_addr, q_len, req_cnt, sent_cnt;
    logic              q_rev, overflow;
    logic [CW-1:0]     outstanding, fifo_count;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic              start, issue, ret, push, pop, complete;

    assign start = config_valid && (config_payload_length != '0) &&
                   ((ctimer == config_payload_timerInit) ||
                    (config_payload_timerInit == TIMER_ALL_ONES));

    // a new read is allowed only while every in-flight word has a FIFO slot
    assign i0_valid = (state == S_RUN) && (req_cnt < q_len) &&
                      (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
    assign i0_addr  = q_addr;
    assign issue    = i0_valid && i0_ready;
    assign ret      = i0_rdata_valid && (state != S_WAIT);
    assign push     = i0_rdata_valid && (state == S_RUN);

    assign t0_valid = (state == S_RUN) && !fifo_empty;
    assign t0_data  = t0_valid ? fifo_head : '0;
    assign t0_last  = t0_valid && (sent_cnt == q_len - 32'd1);
    assign pop      = t0_valid && t0_ready;
    assign complete = (state == S_RUN) && !dmaReset && t0_last && t0_ready;

    dma_out_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .srst     (srst),
        .push     (push),
        .pop      (pop),
        .flush    (state == S_DRAIN),
        .data_in  (i0_rdata),
        .data_out (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    // state register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= S_WAIT;
        else      state <= state_nx;
    end

    // next state and config handshake; abort outranks completion
    always_comb begin
        state_nx     = state;
        config_ready = 1'b0;
        case (state)
            S_WAIT: begin
                if (start) state_nx = S_RUN;
                else if (config_valid && config_payload_length == '0) config_ready = 1'b1;
            end
            S_RUN: begin
                if (dmaReset) begin
                    state_nx = S_DRAIN;
                end else if (complete) begin
                    config_ready = 1'b1;
                    state_nx     = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    config_ready = 1'b1;
                    state_nx     = S_WAIT;
                end
            end
            default: state_nx = S_WAIT;
        endcase
    end

    // transfer datapath: address walk, counters, credits and overflow flag
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            q_addr      <= '0;
            q_len       <= '0;
            q_rev       <= 1'b0;
            req_cnt     <= '0;
            sent_cnt    <= '0;
            outstanding <= '0;
            overflow    <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                if (start) begin
                    q_addr   <= config_payload_startAddr;
                    q_len    <= config_payload_length;
                    q_rev    <= config_payload_reverse;
                    req_cnt  <= '0;
                    sent_cnt <= '0;
                    overflow <= 1'b0;
                end else if (config_valid && config_payload_length == '0) begin
                    overflow <= 1'b0;
                end
            end
            if (issue) begin
                q_addr  <= q_rev ? q_addr - 32'd1 : q_addr + 32'd1;
                req_cnt <= req_cnt + 32'd1;
            end
            if (pop) sent_cnt <= sent_cnt + 32'd1;
            if (push && fifo_full) overflow <= 1'b1;
            case ({issue, ret})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // completion strobe and sticky interrupt; a set beats a same-cycle clear
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            strobe_complete <= 1'b0;
            interrupt       <= 1'b0;
        end else begin
            strobe_complete <= complete;
            if (complete)             interrupt <= 1'b1;
            else if (interrupt_clear) interrupt <= 1'b0;
        end
    end

    // status word assembly
    always_comb begin
        status = '0;
        status[STATUS_OUT_LSB +: STATUS_OUT_W] = STATUS_OUT_W'(outstanding);
        status[STATUS_OVF_BIT] = overflow;
    end

endmodule
